// File: rtl/hdc_dlmon_pkg.sv
// Shared definitions for the HDC deadlock monitor: FSM state codes,
// block-cause encodings and the width helper for the axis index output.
package hdc_dlmon_pkg;

   // FSM state codes (kept as plain constants for legacy tool flows)
   localparam logic [1:0] MONITOR  = 2'd0;
   localparam logic [1:0] SUSPECT  = 2'd1;
   localparam logic [1:0] DEADLOCK = 2'd2;

   // Cause encoding: bit 0 = an AXI-Stream port blocked, bit 1 = an instance blocked
   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_AXIS = 2'b01;
   localparam logic [1:0] CAUSE_INST = 2'b10;
   localparam logic [1:0] CAUSE_BOTH = 2'b11;

   // Width of block_axis_idx: enough bits for every index plus one extra
   // MSB so that the "no axis blocked" code never aliases a real index.
   function automatic int idx_width(input int n);
      return $clog2(n) + 1;
   endfunction

   // Width of the raw encoder output; a single-input encoder still needs one bit.
   function automatic int enc_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Builds the cause code from the two blocked-source summaries.
   function automatic logic [1:0] cause_of(input logic axis_any, input logic inst_any);
      logic [1:0] c;
      c = CAUSE_NONE;
      if (axis_any && inst_any) begin
         c = CAUSE_BOTH;
      end else if (axis_any) begin
         c = CAUSE_AXIS;
      end else if (inst_any) begin
         c = CAUSE_INST;
      end else begin
         c = CAUSE_NONE;
      end
      return c;
   endfunction

endpackage

// File: rtl/hdc_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag. Bit 0 has the highest
// priority; idx is 0 when no request bit is set (valid = 0).
module hdc_prio_enc
   import hdc_dlmon_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = enc_width(N)
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx   = {IW{1'b0}};
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         idx   = req[i] ? IW'(i) : idx;
         valid = valid | req[i];
      end
   end

endmodule

// File: rtl/hdc_deadlock_monitor.sv
// Deadlock watchdog for the HDC kernel dataflow instances and AXI-Stream
// ports. A global stall (every instance idle or blocked, at least one
// source blocked) must persist for TIMEOUT_CYCLES enabled cycles before the
// sticky block flag is raised. Cause and lowest blocked axis index are
// captured on entry to DEADLOCK and frozen until clear or reset.
//
// Optional build feature: define HDC_DEADLOCK_SNAPSHOT_EN to build the
// snap_axis / snap_inst capture registers; otherwise those outputs are 0.
module hdc_deadlock_monitor
   import hdc_dlmon_pkg::*;
#(
   parameter int NUM_AXIS       = 2,
   parameter int NUM_INST       = 2,
   parameter int TIMEOUT_W      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       kernel_monitor_clock,
   input  logic                       kernel_monitor_reset,
   input  logic                       enable,
   input  logic                       clear,
   input  logic [NUM_AXIS-1:0]        axis_block_sigs,
   input  logic [NUM_INST-1:0]        inst_idle_sigs,
   input  logic [NUM_INST-1:0]        inst_block_sigs,
   output logic                       block,
   output logic [1:0]                 block_cause,
   output logic [$clog2(NUM_AXIS):0]  block_axis_idx,
   output logic [TIMEOUT_W-1:0]       stall_count,
   output logic [NUM_AXIS-1:0]        snap_axis,
   output logic [NUM_INST-1:0]        snap_inst
);

   localparam int IDX_W = idx_width(NUM_AXIS);
   localparam int ENC_W = enc_width(NUM_AXIS);

   localparam logic [TIMEOUT_W-1:0] TIMEOUT_V = TIMEOUT_W'(TIMEOUT_CYCLES);
   localparam logic [TIMEOUT_W-1:0] CNT_MAX   = {TIMEOUT_W{1'b1}};
   localparam logic [TIMEOUT_W-1:0] CNT_ONE   = TIMEOUT_W'(1);
   localparam logic [TIMEOUT_W-1:0] CNT_ZERO  = {TIMEOUT_W{1'b0}};
   // "No axis blocked": MSB set, all lower bits clear.
   localparam logic [IDX_W-1:0]     IDX_NONE  = IDX_W'(1) << (IDX_W - 1);
   localparam logic [IDX_W-1:0]     IDX_ZERO  = {IDX_W{1'b0}};

   // Internal state
   logic [1:0]           state_r;
   logic [1:0]           state_nxt_s;
   logic [TIMEOUT_W-1:0] count_r;
   logic [TIMEOUT_W-1:0] count_nxt_s;
   logic [TIMEOUT_W-1:0] count_inc_s;
   logic                 block_r;
   logic [1:0]           cause_r;
   logic [IDX_W-1:0]     idx_r;

   // Stall detection and capture-time values
   logic                 axis_any_s;
   logic                 inst_any_s;
   logic                 any_blk_s;
   logic                 all_parked_s;
   logic                 stalled_s;
   logic                 capture_s;
   logic [ENC_W-1:0]     enc_idx_s;
   logic                 enc_valid_s;
   logic [IDX_W-1:0]     axis_idx_s;

   hdc_prio_enc #(
      .N  (NUM_AXIS),
      .IW (ENC_W)
   ) u_axis_enc (
      .req   (axis_block_sigs),
      .idx   (enc_idx_s),
      .valid (enc_valid_s)
   );

   // Global-stall qualification: an all-idle kernel with nothing blocked is
   // simply finished, not deadlocked, so at least one blocked source is needed.
   always_comb begin
      axis_any_s   = |axis_block_sigs;
      inst_any_s   = |inst_block_sigs;
      any_blk_s    = axis_any_s | inst_any_s;
      all_parked_s = &(inst_idle_sigs | inst_block_sigs);
      stalled_s    = any_blk_s & all_parked_s;
      if (enc_valid_s) begin
         axis_idx_s = IDX_W'(enc_idx_s);
      end else begin
         axis_idx_s = IDX_NONE;
      end
   end

   // Saturating increment so the counter can never wrap.
   always_comb begin
      if (count_r == CNT_MAX) begin
         count_inc_s = count_r;
      end else begin
         count_inc_s = count_r + CNT_ONE;
      end
   end

   // Next-state and counter logic; clear beats everything, a low enable freezes.
   always_comb begin
      state_nxt_s = state_r;
      count_nxt_s = count_r;
      capture_s   = 1'b0;
      if (clear) begin
         state_nxt_s = MONITOR;
         count_nxt_s = CNT_ZERO;
      end else if (!enable) begin
         state_nxt_s = state_r;
         count_nxt_s = count_r;
      end else begin
         case (state_r)
            MONITOR: begin
               if (stalled_s) begin
                  count_nxt_s = CNT_ONE;
                  if (TIMEOUT_V == CNT_ONE) begin
                     state_nxt_s = DEADLOCK;
                     capture_s   = 1'b1;
                  end else begin
                     state_nxt_s = SUSPECT;
                  end
               end else begin
                  state_nxt_s = MONITOR;
                  count_nxt_s = CNT_ZERO;
               end
            end
            SUSPECT: begin
               if (stalled_s) begin
                  count_nxt_s = count_inc_s;
                  if (count_inc_s == TIMEOUT_V) begin
                     state_nxt_s = DEADLOCK;
                     capture_s   = 1'b1;
                  end else begin
                     state_nxt_s = SUSPECT;
                  end
               end else begin
                  state_nxt_s = MONITOR;
                  count_nxt_s = CNT_ZERO;
               end
            end
            DEADLOCK: begin
               // Sticky: only clear or reset leaves this state.
               state_nxt_s = DEADLOCK;
               count_nxt_s = TIMEOUT_V;
            end
            default: begin
               state_nxt_s = MONITOR;
               count_nxt_s = CNT_ZERO;
            end
         endcase
      end
   end

   // FSM state and stall counter registers.
   always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
      if (!kernel_monitor_reset) begin
         state_r <= MONITOR;
         count_r <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         count_r <= count_nxt_s;
      end
   end

   // Sticky deadlock status: captured once on DEADLOCK entry, frozen afterwards.
   always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
      if (!kernel_monitor_reset) begin
         block_r <= 1'b0;
         cause_r <= CAUSE_NONE;
         idx_r   <= IDX_ZERO;
      end else if (clear) begin
         block_r <= 1'b0;
         cause_r <= CAUSE_NONE;
         idx_r   <= IDX_ZERO;
      end else if (capture_s) begin
         block_r <= 1'b1;
         cause_r <= cause_of(axis_any_s, inst_any_s);
         idx_r   <= axis_idx_s;
      end else begin
         block_r <= block_r;
         cause_r <= cause_r;
         idx_r   <= idx_r;
      end
   end

`ifdef HDC_DEADLOCK_SNAPSHOT_EN
   logic [NUM_AXIS-1:0] snap_axis_r;
   logic [NUM_INST-1:0] snap_inst_r;

   // Raw blocked-signal snapshot taken on DEADLOCK entry for post-mortem debug.
   always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
      if (!kernel_monitor_reset) begin
         snap_axis_r <= {NUM_AXIS{1'b0}};
         snap_inst_r <= {NUM_INST{1'b0}};
      end else if (clear) begin
         snap_axis_r <= {NUM_AXIS{1'b0}};
         snap_inst_r <= {NUM_INST{1'b0}};
      end else if (capture_s) begin
         snap_axis_r <= axis_block_sigs;
         snap_inst_r <= inst_block_sigs;
      end else begin
         snap_axis_r <= snap_axis_r;
         snap_inst_r <= snap_inst_r;
      end
   end

   assign snap_axis = snap_axis_r;
   assign snap_inst = snap_inst_r;
`else
   assign snap_axis = {NUM_AXIS{1'b0}};
   assign snap_inst = {NUM_INST{1'b0}};
`endif

   assign block          = block_r;
   assign block_cause    = cause_r;
   assign block_axis_idx = idx_r;
   assign stall_count    = count_r;

endmodule

// File: tb/tb_hdc_deadlock_monitor.sv
// Scoreboard bench for hdc_deadlock_monitor (NUM_AXIS=2, NUM_INST=2,
// TIMEOUT_CYCLES=8). Stimulus pushes the hand-computed post-edge outputs
// into a queue; a monitor pops and compares one entry after every edge.
module tb_hdc_deadlock_monitor;

   localparam int T = 8;

`ifdef HDC_DEADLOCK_SNAPSHOT_EN
   localparam bit SNAP_ON = 1'b1;
`else
   localparam bit SNAP_ON = 1'b0;
`endif

   typedef struct {
      int          tid;
      logic        blk;
      logic [1:0]  cause;
      logic [1:0]  idx;
      logic [15:0] cnt;
      logic [1:0]  sa;
      logic [1:0]  si;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        clear;
   logic [1:0]  axis_b;
   logic [1:0]  inst_i;
   logic [1:0]  inst_b;
   logic        block;
   logic [1:0]  block_cause;
   logic [1:0]  block_axis_idx;
   logic [15:0] stall_count;
   logic [1:0]  snap_axis;
   logic [1:0]  snap_inst;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   hdc_deadlock_monitor #(
      .NUM_AXIS       (2),
      .NUM_INST       (2),
      .TIMEOUT_W      (16),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .kernel_monitor_clock (clk),
      .kernel_monitor_reset (rst_n),
      .enable               (enable),
      .clear                (clear),
      .axis_block_sigs      (axis_b),
      .inst_idle_sigs       (inst_i),
      .inst_block_sigs      (inst_b),
      .block                (block),
      .block_cause          (block_cause),
      .block_axis_idx       (block_axis_idx),
      .stall_count          (stall_count),
      .snap_axis            (snap_axis),
      .snap_inst            (snap_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue the expected post-edge outputs.
   task automatic step(input int tid, input logic [1:0] ax, input logic [1:0] id,
                       input logic [1:0] bl, input logic en, input logic cl,
                       input logic eb, input logic [1:0] ec, input logic [1:0] ei,
                       input int ecnt, input logic [1:0] esa, input logic [1:0] esi);
      exp_t e;
      @(negedge clk);
      axis_b = ax;
      inst_i = id;
      inst_b = bl;
      enable = en;
      clear  = cl;
      e.tid   = tid;
      e.blk   = eb;
      e.cause = ec;
      e.idx   = ei;
      e.cnt   = 16'(ecnt);
      e.sa    = SNAP_ON ? esa : 2'b00;
      e.si    = SNAP_ON ? esi : 2'b00;
      q.push_back(e);
   endtask

   // Idle / no-block cycle expecting every output at zero.
   task automatic idle_zero(input int tid, input logic cl);
      step(tid, 2'b00, 2'b11, 2'b00, 1'b1, cl, 1'b0, 2'b00, 2'b00, 0, 2'b00, 2'b00);
   endtask

   // Immediate check (between edges) that all outputs are at reset values.
   task automatic chk_zero_now(input int tid);
      checks++;
      if ({block, block_cause, block_axis_idx, stall_count, snap_axis, snap_inst} !== 25'd0) begin
         errors++;
         $display("FAIL reset_now t%0d: got blk=%b cause=%b idx=%b cnt=%0d sa=%b si=%b, want all 0",
                  tid, block, block_cause, block_axis_idx, stall_count, snap_axis, snap_inst);
      end
   endtask

   // Monitor: compare one queued expectation just after each active edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (block !== e.blk || block_cause !== e.cause || block_axis_idx !== e.idx ||
             stall_count !== e.cnt || snap_axis !== e.sa || snap_inst !== e.si) begin
            errors++;
            $display("FAIL sb t%0d: got blk=%b cause=%b idx=%b cnt=%0d sa=%b si=%b, want blk=%b cause=%b idx=%b cnt=%0d sa=%b si=%b",
                     e.tid, block, block_cause, block_axis_idx, stall_count, snap_axis, snap_inst,
                     e.blk, e.cause, e.idx, e.cnt, e.sa, e.si);
         end
      end
   end

   // Global watchdog so the bench can never hang.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Wait (bounded) for the scoreboard to empty.
   task automatic drain();
      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
   endtask

   // Directed stimulus. Stall pattern S: axis=01, idle=01, block=10.
   initial begin
      rst_n  = 1'b0;
      enable = 1'b1;
      clear  = 1'b0;
      axis_b = 2'b00;
      inst_i = 2'b00;
      inst_b = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk_zero_now(0);
      @(negedge clk);
      rst_n = 1'b1;

      // t1: 8 stalled cycles to block, cause both, idx 0; then sticky.
      for (int k = 1; k < T; k++)
         step(1, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, k, 2'b00, 2'b00);
      step(1, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1, 2'b11, 2'b00, 8, 2'b01, 2'b10);
      repeat (2)
         step(1, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1, 2'b11, 2'b00, 8, 2'b01, 2'b10);
      // t4: inputs release, deadlock stays; clear drops everything.
      repeat (3)
         step(4, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b11, 2'b00, 8, 2'b01, 2'b10);
      idle_zero(4, 1'b1);
      idle_zero(4, 1'b0);

      // t2: stall broken after 5 cycles restarts the count.
      for (int k = 1; k <= 5; k++)
         step(2, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, k, 2'b00, 2'b00);
      step(2, 2'b01, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 0, 2'b00, 2'b00);
      for (int k = 1; k < T; k++)
         step(2, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, k, 2'b00, 2'b00);
      step(2, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1, 2'b11, 2'b00, 8, 2'b01, 2'b10);
      idle_zero(2, 1'b1);

      // t3: all idle, nothing blocked, 100 cycles: never a stall.
      repeat (100) idle_zero(3, 1'b0);

      // t5: enable low for 3 cycles at count 4 delays detection by 3.
      for (int k = 1; k <= 4; k++)
         step(5, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, k, 2'b00, 2'b00);
      repeat (3)
         step(5, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4, 2'b00, 2'b00);
      for (int k = 5; k < T; k++)
         step(5, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, k, 2'b00, 2'b00);
      step(5, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1, 2'b11, 2'b00, 8, 2'b01, 2'b10);
      idle_zero(5, 1'b1);

      // t7: clear wins over a same-cycle stall increment.
      for (int k = 1; k <= 3; k++)
         step(7, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, k, 2'b00, 2'b00);
      step(7, 2'b01, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 0, 2'b00, 2'b00);
      step(7, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1, 2'b00, 2'b00);
      idle_zero(7, 1'b1);

      // t8: instance-only stall: cause 10, idx "none" = 10.
      for (int k = 1; k < T; k++)
         step(8, 2'b00, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, k, 2'b00, 2'b00);
      step(8, 2'b00, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 8, 2'b00, 2'b10);
      idle_zero(8, 1'b1);

      // t6: axis bit 1 blocked: idx 1, snapshot axis 10; then async reset.
      for (int k = 1; k < T; k++)
         step(6, 2'b10, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, k, 2'b00, 2'b00);
      step(6, 2'b10, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1, 2'b11, 2'b01, 8, 2'b10, 2'b10);
      step(6, 2'b10, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1, 2'b11, 2'b01, 8, 2'b10, 2'b10);
      drain();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero_now(6);
      axis_b = 2'b00;
      inst_i = 2'b11;
      inst_b = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      idle_zero(6, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
